// File: rtl/cache_req_pkg.sv
// ---------------------------------------------------------------------------
// cache_req_pkg
// Shared definitions for the cache bank requester: default geometry, the
// per-bank state encoding and the address-to-bank interleave helper.
// ---------------------------------------------------------------------------
package cache_req_pkg;

  localparam int unsigned NBANKS_DEFAULT  = 16;
  localparam int unsigned AW_DEFAULT      = 32;
  localparam int unsigned DW_DEFAULT      = 32;
  localparam int unsigned TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } bank_state_e;

  // Word interleave: consecutive 32-bit words land in consecutive banks.
  // The caller truncates the result to log2(nbanks) bits.
  function automatic logic [63:0] bank_sel(input logic [63:0] addr,
                                           input int unsigned nbanks);
    return (addr >> 2) & (64'(nbanks) - 64'd1);
  endfunction

endpackage

// File: rtl/cache_bank_req_fsm.sv
// ---------------------------------------------------------------------------
// cache_bank_req_fsm
// One bank's request tracker. Holds the request address while Req is high,
// captures Ack data (or flags a timeout), and parks the result until the
// response is popped upstream.
//
// Ports:
//   CLK, RSTn    clock, asynchronous active-low reset
//   start_i      accept a new request for this bank (only honoured in IDLE)
//   addr_i       address of the accepted request
//   ack_i        bank acknowledge pulse
//   data_i       bank read data, valid with ack_i
//   pop_i        upstream consumed this bank's response
//   req_o        bank request level
//   addr_o       bank address (stable while req_o is high)
//   idle_o       bank can take a new request
//   done_o       response is ready in data_o/err_o
//   data_o       captured read data (0 after timeout)
//   err_o        1 = request timed out
//   spurious_o   ack_i seen while not waiting for one
// ---------------------------------------------------------------------------
module cache_bank_req_fsm
  import cache_req_pkg::*;
#(
  parameter int unsigned AW      = AW_DEFAULT,
  parameter int unsigned DW      = DW_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          start_i,
  input  logic [AW-1:0] addr_i,
  input  logic          ack_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic          req_o,
  output logic [AW-1:0] addr_o,
  output logic          idle_o,
  output logic          done_o,
  output logic [DW-1:0] data_o,
  output logic          err_o,
  output logic          spurious_o
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  bank_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          err_q, err_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = REQ;
          addr_d  = addr_i;
          cnt_d   = '0;
        end
      end
      REQ: begin
        // Ack is checked first so that an Ack landing on the final
        // timeout cycle still returns good data.
        if (ack_i) begin
          state_d = DONE;
          data_d  = data_i;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          data_d  = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (pop_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign req_o      = (state_q == REQ);
  assign idle_o     = (state_q == IDLE);
  assign done_o     = (state_q == DONE);
  assign addr_o     = addr_q;
  assign data_o     = data_q;
  assign err_o      = err_q;
  // Covers both stray Acks in IDLE and late Acks after a timeout.
  assign spurious_o = ack_i && (state_q != REQ);

endmodule

// File: rtl/cache_bank_requester.sv
// ---------------------------------------------------------------------------
// cache_bank_requester
// Initiator side of the banked cache port. Accepts upstream reads, steers
// each to a bank by word interleave, keeps one request per bank in flight
// and returns responses strictly in accept order.
//
// Ports:
//   CLK, RSTn       clock, asynchronous active-low reset
//   Up_Req_Valid    upstream request valid
//   Up_Req_Ready    request accepted when Valid && Ready
//   Up_Req_Addr     byte address
//   Up_Resp_Valid   response valid
//   Up_Resp_Ready   upstream takes response
//   Up_Resp_Data    read data (0 on error)
//   Up_Resp_Err     1 = bank timed out
//   Bank_Req        per-bank request level
//   Bank_Addr       per-bank address, bank i at [i*AW +: AW]
//   Bank_Data       per-bank read data, bank i at [i*DW +: DW]
//   Bank_Ack        per-bank acknowledge pulse
//   Spurious_Ack    sticky: Ack seen on a bank not waiting for one
// ---------------------------------------------------------------------------
module cache_bank_requester
  import cache_req_pkg::*;
#(
  parameter int unsigned NBANKS  = NBANKS_DEFAULT,
  parameter int unsigned AW      = AW_DEFAULT,
  parameter int unsigned DW      = DW_DEFAULT,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 Up_Req_Valid,
  output logic                 Up_Req_Ready,
  input  logic [AW-1:0]        Up_Req_Addr,
  output logic                 Up_Resp_Valid,
  input  logic                 Up_Resp_Ready,
  output logic [DW-1:0]        Up_Resp_Data,
  output logic                 Up_Resp_Err,
  output logic [NBANKS-1:0]    Bank_Req,
  output logic [NBANKS*AW-1:0] Bank_Addr,
  input  logic [NBANKS*DW-1:0] Bank_Data,
  input  logic [NBANKS-1:0]    Bank_Ack,
  output logic                 Spurious_Ack
);

  localparam int unsigned BW   = $clog2(NBANKS);
  localparam int unsigned CNTW = BW + 1;
  localparam logic [CNTW-1:0] FIFO_DEPTH = CNTW'(NBANKS);

  logic [BW-1:0]     req_sel;
  logic              accept;
  logic              pop;
  logic              resp_valid;
  logic [BW-1:0]     head_bank;
  logic              fifo_full;

  logic [NBANKS-1:0] bank_idle;
  logic [NBANKS-1:0] bank_done;
  logic [NBANKS-1:0] bank_req;
  logic [NBANKS-1:0] bank_err;
  logic [NBANKS-1:0] bank_spur;
  logic [DW-1:0]     bank_data [NBANKS];

  // Order FIFO: bank IDs in accept order. Pointers wrap naturally because
  // NBANKS is a power of two.
  logic [BW-1:0]     fifo_mem [NBANKS];
  logic [BW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [BW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              spurious_q, spurious_d;

  assign req_sel   = BW'(bank_sel(64'(Up_Req_Addr), NBANKS));
  assign fifo_full = (count_q == FIFO_DEPTH);
  assign head_bank = fifo_mem[rd_ptr_q];

  // A bank being popped this cycle is still DONE, so a same-cycle accept to
  // it is refused here and retried next cycle.
  assign Up_Req_Ready = bank_idle[req_sel] && !fifo_full;
  assign accept       = Up_Req_Valid && Up_Req_Ready;

  assign resp_valid    = (count_q != '0) && bank_done[head_bank];
  assign pop           = resp_valid && Up_Resp_Ready;
  assign Up_Resp_Valid = resp_valid;
  assign Up_Resp_Data  = resp_valid ? bank_data[head_bank] : '0;
  assign Up_Resp_Err   = resp_valid && bank_err[head_bank];
  assign Bank_Req      = bank_req;
  assign Spurious_Ack  = spurious_q;

  generate
    for (genvar gi = 0; gi < NBANKS; gi++) begin : g_bank
      cache_bank_req_fsm #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
      ) u_fsm (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .start_i    (accept && (req_sel == BW'(gi))),
        .addr_i     (Up_Req_Addr),
        .ack_i      (Bank_Ack[gi]),
        .data_i     (Bank_Data[gi*DW +: DW]),
        .pop_i      (pop && (head_bank == BW'(gi))),
        .req_o      (bank_req[gi]),
        .addr_o     (Bank_Addr[gi*AW +: AW]),
        .idle_o     (bank_idle[gi]),
        .done_o     (bank_done[gi]),
        .data_o     (bank_data[gi]),
        .err_o      (bank_err[gi]),
        .spurious_o (bank_spur[gi])
      );
    end
  endgenerate

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    spurious_d = spurious_q | (|bank_spur);
    if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      spurious_q <= spurious_d;
    end
  end

  // Entry storage needs no reset: count_q gates every read of it.
  always_ff @(posedge CLK) begin
    if (accept) begin
      fifo_mem[wr_ptr_q] <= req_sel;
    end
  end

endmodule

// File: tb/tb_cache_bank_requester.sv
module tb_cache_bank_requester;

  localparam int NB = 16;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 64;

  logic                CLK;
  logic                RSTn;
  logic                Up_Req_Valid;
  logic                Up_Req_Ready;
  logic [AW-1:0]       Up_Req_Addr;
  logic                Up_Resp_Valid;
  logic                Up_Resp_Ready;
  logic [DW-1:0]       Up_Resp_Data;
  logic                Up_Resp_Err;
  logic [NB-1:0]       Bank_Req;
  logic [NB*AW-1:0]    Bank_Addr;
  logic [NB*DW-1:0]    Bank_Data;
  logic [NB-1:0]       Bank_Ack;
  logic                Spurious_Ack;

  int checks = 0;
  int errors = 0;

  cache_bank_requester #(
    .NBANKS  (NB),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TO)
  ) dut (
    .CLK           (CLK),
    .RSTn          (RSTn),
    .Up_Req_Valid  (Up_Req_Valid),
    .Up_Req_Ready  (Up_Req_Ready),
    .Up_Req_Addr   (Up_Req_Addr),
    .Up_Resp_Valid (Up_Resp_Valid),
    .Up_Resp_Ready (Up_Resp_Ready),
    .Up_Resp_Data  (Up_Resp_Data),
    .Up_Resp_Err   (Up_Resp_Err),
    .Bank_Req      (Bank_Req),
    .Bank_Addr     (Bank_Addr),
    .Bank_Data     (Bank_Data),
    .Bank_Ack      (Bank_Ack),
    .Spurious_Ack  (Spurious_Ack)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0] addr;
    int            delay;
    logic [DW-1:0] data;
    int            bank;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic ack_bank(input int b, input logic [DW-1:0] d);
    Bank_Ack[b] = 1'b1;
    Bank_Data[b*DW +: DW] = d;
    tick();
    Bank_Ack[b] = 1'b0;
    Bank_Data = '0;
  endtask

  function automatic logic [63:0] onehot(input int b);
    logic [63:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  // Single read: accept, hold Req for 'delay' extra cycles, Ack, pop.
  task automatic run_read(input logic [AW-1:0] addr, input int delay,
                          input logic [DW-1:0] data, input int bank);
    Up_Req_Valid = 1'b1;
    Up_Req_Addr  = addr;
    settle();
    chk("rd_ready", 64'(Up_Req_Ready), 64'd1);
    tick();
    Up_Req_Valid = 1'b0;
    chk("rd_req_onehot", 64'(Bank_Req), onehot(bank));
    chk("rd_bank_addr", 64'(Bank_Addr[bank*AW +: AW]), 64'(addr));
    for (int k = 0; k < delay; k++) begin
      tick();
      chk("rd_req_hold", 64'(Bank_Req), onehot(bank));
      chk("rd_no_valid_yet", 64'(Up_Resp_Valid), 64'd0);
    end
    ack_bank(bank, data);
    chk("rd_req_dropped", 64'(Bank_Req), 64'd0);
    chk("rd_resp_valid", 64'(Up_Resp_Valid), 64'd1);
    chk("rd_resp_data", 64'(Up_Resp_Data), 64'(data));
    chk("rd_resp_err", 64'(Up_Resp_Err), 64'd0);
    Up_Resp_Ready = 1'b1;
    tick();
    Up_Resp_Ready = 1'b0;
    chk("rd_popped", 64'(Up_Resp_Valid), 64'd0);
    $display("txn read addr=0x%08h bank=%0d ack_delay=%0d data=0x%08h", addr, bank, delay, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0] = '{addr: 32'h0000_0014, delay: 3, data: 32'hDEAD_BEEF, bank: 5};
    vecs[1] = '{addr: 32'h0000_0000, delay: 0, data: 32'h1111_1111, bank: 0};
    vecs[2] = '{addr: 32'h0000_003C, delay: 1, data: 32'hA5A5_A5A5, bank: 15};
    vecs[3] = '{addr: 32'h0000_0040, delay: 2, data: 32'h1234_5678, bank: 0};
    vecs[4] = '{addr: 32'hFFFF_FFFF, delay: 0, data: 32'hCAFE_F00D, bank: 15};
    vecs[5] = '{addr: 32'h1236_0027, delay: 4, data: 32'h0BAD_C0DE, bank: 9};
    vecs[6] = '{addr: 32'h0000_0008, delay: 1, data: 32'h0000_0000, bank: 2};

    RSTn          = 1'b1;
    Up_Req_Valid  = 1'b0;
    Up_Req_Addr   = '0;
    Up_Resp_Ready = 1'b0;
    Bank_Data     = '0;
    Bank_Ack      = '0;
    #1 RSTn = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_bank_req", 64'(Bank_Req), 64'd0);
    chk("rst_bank_addr_zero", 64'(Bank_Addr == '0), 64'd1);
    chk("rst_req_ready", 64'(Up_Req_Ready), 64'd1);
    chk("rst_resp_valid", 64'(Up_Resp_Valid), 64'd0);
    chk("rst_resp_data", 64'(Up_Resp_Data), 64'd0);
    chk("rst_resp_err", 64'(Up_Resp_Err), 64'd0);
    chk("rst_spurious", 64'(Spurious_Ack), 64'd0);
    RSTn = 1'b1;
    tick();

    // Table-driven single reads
    for (int i = 0; i < 7; i++) begin
      run_read(vecs[i].addr, vecs[i].delay, vecs[i].data, vecs[i].bank);
    end

    // Back-to-back reads to banks 2 and 7, bank 7 answers first
    Up_Req_Valid = 1'b1;
    Up_Req_Addr  = 32'h0000_0008;
    tick();
    Up_Req_Addr  = 32'h0000_001C;
    settle();
    chk("b2b_ready_second", 64'(Up_Req_Ready), 64'd1);
    tick();
    Up_Req_Valid = 1'b0;
    chk("b2b_both_req", 64'(Bank_Req), 64'h0084);
    ack_bank(7, 32'h0000_0077);
    chk("b2b_young_held", 64'(Up_Resp_Valid), 64'd0);
    chk("b2b_bank2_still_req", 64'(Bank_Req), 64'h0004);
    for (int k = 0; k < 4; k++) tick();
    chk("b2b_still_held", 64'(Up_Resp_Valid), 64'd0);
    ack_bank(2, 32'h0000_0022);
    chk("b2b_first_valid", 64'(Up_Resp_Valid), 64'd1);
    chk("b2b_first_data", 64'(Up_Resp_Data), 64'h22);
    Up_Resp_Ready = 1'b1;
    tick();
    chk("b2b_second_valid", 64'(Up_Resp_Valid), 64'd1);
    chk("b2b_second_data", 64'(Up_Resp_Data), 64'h77);
    tick();
    Up_Resp_Ready = 1'b0;
    chk("b2b_drained", 64'(Up_Resp_Valid), 64'd0);
    $display("txn order banks 2,7 responses 0x22 then 0x77");

    // Two reads to bank 3: second waits for the pop, then issues next cycle
    Up_Req_Valid = 1'b1;
    Up_Req_Addr  = 32'h0000_000C;
    tick();
    Up_Req_Addr  = 32'h0000_004C;
    settle();
    chk("same_bank_stall_req", 64'(Up_Req_Ready), 64'd0);
    ack_bank(3, 32'h0000_0033);
    chk("same_bank_stall_done", 64'(Up_Req_Ready), 64'd0);
    chk("same_bank_resp_data", 64'(Up_Resp_Data), 64'h33);
    Up_Resp_Ready = 1'b1;
    settle();
    chk("same_bank_pop_cycle_refused", 64'(Up_Req_Ready), 64'd0);
    tick();
    Up_Resp_Ready = 1'b0;
    chk("same_bank_ready_after_pop", 64'(Up_Req_Ready), 64'd1);
    chk("same_bank_no_req_yet", 64'(Bank_Req), 64'd0);
    tick();
    Up_Req_Valid = 1'b0;
    chk("same_bank_second_req", 64'(Bank_Req), 64'h0008);
    chk("same_bank_second_addr", 64'(Bank_Addr[3*AW +: AW]), 64'h4C);
    ack_bank(3, 32'h0000_0034);
    chk("same_bank_second_data", 64'(Up_Resp_Data), 64'h34);
    Up_Resp_Ready = 1'b1;
    tick();
    Up_Resp_Ready = 1'b0;
    $display("txn bank 3 twice, second issued after pop");

    // Ack on the last timeout cycle: Ack wins
    Up_Req_Valid = 1'b1;
    Up_Req_Addr  = 32'h0000_0010;
    tick();
    Up_Req_Valid = 1'b0;
    for (int k = 0; k < TO - 1; k++) tick();
    chk("ackwin_req_still_high", 64'(Bank_Req), 64'h0010);
    ack_bank(4, 32'h4444_4444);
    chk("ackwin_valid", 64'(Up_Resp_Valid), 64'd1);
    chk("ackwin_data", 64'(Up_Resp_Data), 64'h4444_4444);
    chk("ackwin_err", 64'(Up_Resp_Err), 64'd0);
    chk("ackwin_no_spurious", 64'(Spurious_Ack), 64'd0);
    Up_Resp_Ready = 1'b1;
    tick();
    Up_Resp_Ready = 1'b0;
    $display("txn bank 4 ack on final timeout cycle");

    // Timeout on bank 9, then a late Ack
    Up_Req_Valid = 1'b1;
    Up_Req_Addr  = 32'h0000_0024;
    tick();
    Up_Req_Valid = 1'b0;
    n = 0;
    while (Bank_Req[9] && n < 200) begin
      n++;
      tick();
    end
    chk("to_req_cycles", 64'(n), 64'(TO));
    chk("to_valid", 64'(Up_Resp_Valid), 64'd1);
    chk("to_data", 64'(Up_Resp_Data), 64'd0);
    chk("to_err", 64'(Up_Resp_Err), 64'd1);
    tick();
    chk("to_spurious_before", 64'(Spurious_Ack), 64'd0);
    ack_bank(9, 32'h9999_9999);
    chk("to_spurious_after", 64'(Spurious_Ack), 64'd1);
    chk("to_stable_data", 64'(Up_Resp_Data), 64'd0);
    chk("to_stable_err", 64'(Up_Resp_Err), 64'd1);
    Up_Resp_Ready = 1'b1;
    tick();
    Up_Resp_Ready = 1'b0;
    chk("to_spurious_sticky", 64'(Spurious_Ack), 64'd1);
    $display("txn bank 9 timeout, late ack flagged");

    // Fill every bank, then reset mid-flight
    Up_Req_Valid = 1'b1;
    for (int b = 0; b < NB; b++) begin
      Up_Req_Addr = AW'(b * 4);
      settle();
      chk("fill_ready", 64'(Up_Req_Ready), 64'd1);
      tick();
    end
    Up_Req_Addr = 32'h0000_1000;
    settle();
    chk("fill_17th_refused", 64'(Up_Req_Ready), 64'd0);
    chk("fill_all_req", 64'(Bank_Req), 64'hFFFF);
    Up_Req_Valid = 1'b0;
    ack_bank(0, 32'h0000_00AB);
    chk("fill_head_valid", 64'(Up_Resp_Valid), 64'd1);
    chk("fill_head_data", 64'(Up_Resp_Data), 64'hAB);
    #2 RSTn = 1'b0;
    #1;
    chk("midrst_bank_req", 64'(Bank_Req), 64'd0);
    chk("midrst_resp_valid", 64'(Up_Resp_Valid), 64'd0);
    chk("midrst_ready", 64'(Up_Req_Ready), 64'd1);
    chk("midrst_spurious", 64'(Spurious_Ack), 64'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("postrst_no_resp", 64'(Up_Resp_Valid), 64'd0);
      chk("postrst_no_req", 64'(Bank_Req), 64'd0);
    end
    $display("txn 16 outstanding, reset discards all");

    run_read(32'h0000_0014, 0, 32'h5555_AAAA, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
